mul_div_unit: RTL and testbench
===============================

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have port iCLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port iRST_n, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have port iStart, input, 1 bit: a request strobe; iControlSignal, iA and iB are valid while it is high.
REQ-004 SHALL have port iControlSignal, input, 5 bits: the ALU control code (OPMULT, OPMULTU, OPDIV, OPDIVU, OPMTHI, OPMTLO, OPMFHI, OPMFLO).
REQ-005 SHALL have port iA, input, 32 bits: the rs operand (dividend / multiplicand / move source).
REQ-006 SHALL have port iB, input, 32 bits: the rt operand (divisor / multiplier).
REQ-007 SHALL have port oBusy, output, 1 bit: high while a multiply or divide is in progress.
REQ-008 SHALL have port oDone, output, 1 bit: a one-cycle completion pulse.
REQ-009 SHALL have port oDivZero, output, 1 bit: pulses with oDone when a divide had iB=0.
REQ-010 SHALL have ports oHI and oLO, outputs, 32 bits each: the architectural HI and LO registers.
REQ-011 SHALL have port oResult, output, 32 bits: the combinational read value; HI for OPMFHI, LO for OPMFLO, else 0.

Function
REQ-012 SHALL implement states IDLE, MUL, DIV and FIN; oBusy=1 exactly in MUL, DIV and FIN.
REQ-013 SHALL accept a request only when iStart=1 and state=IDLE; iStart in any other state is ignored with no side effect.
REQ-014 SHALL latch iA, iB and the signedness on the accept edge; later input changes have no effect on the operation.
REQ-015 SHALL, on accepting MULT/MULTU, enter MUL with the counter at 0 and perform one shift-add step per cycle for 32 cycles, then enter FIN.
REQ-016 SHALL, on accepting DIV/DIVU, enter DIV and perform one restoring step per cycle for 32 cycles, then enter FIN.
REQ-017 SHALL, in FIN, apply sign fix-up, write HI/LO, return to IDLE, and assert oDone for the following cycle only; oBusy is high for exactly 33 cycles.
REQ-018 SHALL, for signed operations, operate on magnitudes and negate the results at FIN; quotient truncates toward zero and the remainder takes the dividend's sign.
REQ-019 SHALL write multiply results as {HI,LO} = 64-bit product, and divide results as LO=quotient, HI=remainder.
REQ-020 SHALL, on a divide with iB=0, keep the 33-cycle latency, write LO=0xFFFFFFFF and HI=iA, and pulse oDivZero with oDone.
REQ-021 SHALL produce LO=0x80000000 and HI=0 for DIV of 0x80000000 by 0xFFFFFFFF, with no flag raised.
REQ-022 SHALL, on accepting OPMTHI/OPMTLO, write iA into HI/LO on the accept edge, stay in IDLE, and pulse oDone the next cycle.
REQ-023 SHALL leave HI/LO unchanged until FIN, so that OPMFHI/OPMFLO reads during busy return the previous values.
REQ-024 SHALL treat OPMFHI/OPMFLO and all other codes as no state change and no oDone, in every state.

Reset
REQ-025 SHALL, while iRST_n=0, force the state to IDLE, the counter to 0, HI=LO=0, and oBusy=oDone=oDivZero=0, regardless of the clock.
REQ-026 SHALL, on reset mid-operation, discard the operation without producing oDone; the first request after deassertion is accepted normally.

Structure
REQ-027 SHALL take all OP* control codes from the shared parameters file used by the ALU control logic; the state encoding and iteration count (32) are local constants.
REQ-028 SHALL place one restoring-division iteration in the sub-module div_step (inputs: partial remainder, quotient, divisor; outputs: next remainder, next quotient).

Verification
REQ-029 Test 1: MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; oBusy high 33 cycles; one oDone pulse.
REQ-030 Test 2: MULT 0xFFFFFFFD x 0x00000007 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
REQ-031 Test 3: DIV 0xFFFFFFF9 / 0x00000002 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7 / 0 -> LO=0xFFFFFFFF, HI=7, oDivZero=1 with oDone.
REQ-032 Test 4: DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0, oDivZero=0.
REQ-033 Test 5: MTHI 0x1234 and then MULTU 2x3; during busy, MTHI 0x9999 is ignored and OPMFHI reads 0x1234; after done, HI=0, LO=6.
REQ-034 Test 6: iRST_n low at iteration 10 of DIVU -> oBusy=0, HI=LO=0 immediately, and no oDone ever.

Source files
------------

// File: rtl/mul_div_unit_pkg.sv
// Shared ALU control codes for the multiply/divide unit and the ALU control logic.
package mul_div_unit_pkg;

   // ALU control codes seen on iControlSignal
   localparam logic [4:0] OPMULT  = 5'd10;
   localparam logic [4:0] OPMULTU = 5'd11;
   localparam logic [4:0] OPDIV   = 5'd12;
   localparam logic [4:0] OPDIVU  = 5'd13;
   localparam logic [4:0] OPMTHI  = 5'd14;
   localparam logic [4:0] OPMTLO  = 5'd15;
   localparam logic [4:0] OPMFHI  = 5'd16;
   localparam logic [4:0] OPMFLO  = 5'd17;

   // Magnitude of a 32-bit value, treating it as signed only when asked to
   function automatic logic [31:0] mag32(input logic [31:0] value, input logic is_signed);
      return (is_signed && value[31]) ? (~value + 32'd1) : value;
   endfunction

endpackage

// File: rtl/mul_div_unit_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, try a subtract.
module div_step (
   input  logic [31:0] i_rem,
   input  logic [31:0] i_quo,
   input  logic [31:0] i_div,
   output logic [31:0] o_rem,
   output logic [31:0] o_quo
);

   logic [32:0] w_shift;
   logic [32:0] w_diff;
   logic        w_fits;

   // Trial subtract; keep the difference only when the divisor fits
   always_comb begin
      w_shift = {i_rem, i_quo[31]};
      w_diff  = w_shift - {1'b0, i_div};
      w_fits  = (w_shift >= {1'b0, i_div});
      o_rem   = w_fits ? w_diff[31:0] : w_shift[31:0];
      o_quo   = {i_quo[30:0], w_fits};
   end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative 32-bit multiply/divide unit with architectural HI/LO registers.
// Multiplies use shift-add, divides use restoring division; both work on
// magnitudes and apply the sign correction in the final state.
module mul_div_unit
   import mul_div_unit_pkg::*;
(
   input  logic        iCLK,
   input  logic        iRST_n,
   input  logic        iStart,
   input  logic [4:0]  iControlSignal,
   input  logic [31:0] iA,
   input  logic [31:0] iB,
   output logic        oBusy,
   output logic        oDone,
   output logic        oDivZero,
   output logic [31:0] oHI,
   output logic [31:0] oLO,
   output logic [31:0] oResult
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_FIN  = 2'd3
   } state_t;

   localparam int         ITERS     = 32;
   localparam logic [4:0] LAST_ITER = 5'(ITERS - 1);

   state_t      r_state;
   logic [4:0]  r_cnt;
   logic [63:0] r_prod;      // multiply: running product; divide: {remainder, quotient}
   logic [31:0] r_opd;       // multiply: multiplicand magnitude; divide: divisor magnitude
   logic [31:0] r_a_raw;     // original dividend, returned in HI on divide-by-zero
   logic        r_is_div;
   logic        r_neg_q;     // negate product / quotient at the end
   logic        r_neg_r;     // negate remainder at the end
   logic        r_div_zero;
   logic [31:0] r_hi;
   logic [31:0] r_lo;
   logic        r_busy;
   logic        r_done;
   logic        r_divz;

   logic        w_is_mul_op;
   logic        w_is_div_op;
   logic        w_op_signed;
   logic [31:0] w_mag_a;
   logic [31:0] w_mag_b;
   logic [32:0] w_add;
   logic [63:0] w_mul_next;
   logic [31:0] w_rem_next;
   logic [31:0] w_quo_next;
   logic [63:0] w_prod_fix;
   logic [31:0] w_quo_fix;
   logic [31:0] w_rem_fix;

   // Decode the request and form operand magnitudes
   always_comb begin
      w_is_mul_op = (iControlSignal == OPMULT) || (iControlSignal == OPMULTU);
      w_is_div_op = (iControlSignal == OPDIV)  || (iControlSignal == OPDIVU);
      w_op_signed = (iControlSignal == OPMULT) || (iControlSignal == OPDIV);
      w_mag_a     = mag32(iA, w_op_signed);
      w_mag_b     = mag32(iB, w_op_signed);
   end

   // One shift-add multiply step: add multiplicand when the low bit is set, then shift right
   always_comb begin
      w_add      = {1'b0, r_prod[63:32]} + (r_prod[0] ? {1'b0, r_opd} : 33'd0);
      w_mul_next = {w_add, r_prod[31:1]};
   end

   div_step u_div_step (
      .i_rem (r_prod[63:32]),
      .i_quo (r_prod[31:0]),
      .i_div (r_opd),
      .o_rem (w_rem_next),
      .o_quo (w_quo_next)
   );

   // Sign correction applied when leaving the final state
   always_comb begin
      w_prod_fix = r_neg_q ? (~r_prod + 64'd1) : r_prod;
      w_quo_fix  = r_neg_q ? (~r_prod[31:0] + 32'd1) : r_prod[31:0];
      w_rem_fix  = r_neg_r ? (~r_prod[63:32] + 32'd1) : r_prod[63:32];
   end

   // Control FSM, datapath registers and registered status outputs
   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
         r_state    <= ST_IDLE;
         r_cnt      <= 5'd0;
         r_prod     <= 64'd0;
         r_opd      <= 32'd0;
         r_a_raw    <= 32'd0;
         r_is_div   <= 1'b0;
         r_neg_q    <= 1'b0;
         r_neg_r    <= 1'b0;
         r_div_zero <= 1'b0;
         r_hi       <= 32'd0;
         r_lo       <= 32'd0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_divz     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_divz <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (iStart) begin
                  if (w_is_mul_op) begin
                     r_state  <= ST_MUL;
                     r_cnt    <= 5'd0;
                     r_busy   <= 1'b1;
                     r_is_div <= 1'b0;
                     r_prod   <= {32'd0, w_mag_b};
                     r_opd    <= w_mag_a;
                     r_neg_q  <= w_op_signed && (iA[31] ^ iB[31]);
                     r_neg_r  <= 1'b0;
                  end else if (w_is_div_op) begin
                     r_state    <= ST_DIV;
                     r_cnt      <= 5'd0;
                     r_busy     <= 1'b1;
                     r_is_div   <= 1'b1;
                     r_prod     <= {32'd0, w_mag_a};
                     r_opd      <= w_mag_b;
                     r_a_raw    <= iA;
                     r_div_zero <= (iB == 32'd0);
                     r_neg_q    <= w_op_signed && (iA[31] ^ iB[31]);
                     r_neg_r    <= w_op_signed && iA[31];
                  end else if (iControlSignal == OPMTHI) begin
                     r_hi   <= iA;
                     r_done <= 1'b1;
                  end else if (iControlSignal == OPMTLO) begin
                     r_lo   <= iA;
                     r_done <= 1'b1;
                  end
               end
            end
            ST_MUL: begin
               r_prod <= w_mul_next;
               r_cnt  <= r_cnt + 5'd1;
               if (r_cnt == LAST_ITER) begin
                  r_state <= ST_FIN;
               end
            end
            ST_DIV: begin
               r_prod <= {w_rem_next, w_quo_next};
               r_cnt  <= r_cnt + 5'd1;
               if (r_cnt == LAST_ITER) begin
                  r_state <= ST_FIN;
               end
            end
            ST_FIN: begin
               if (r_is_div) begin
                  if (r_div_zero) begin
                     r_hi   <= r_a_raw;
                     r_lo   <= 32'hFFFF_FFFF;
                     r_divz <= 1'b1;
                  end else begin
                     r_hi <= w_rem_fix;
                     r_lo <= w_quo_fix;
                  end
               end else begin
                  r_hi <= w_prod_fix[63:32];
                  r_lo <= w_prod_fix[31:0];
               end
               r_state <= ST_IDLE;
               r_cnt   <= 5'd0;
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   // Move-from read port is combinational on the current control code
   always_comb begin
      if (iControlSignal == OPMFHI) begin
         oResult = r_hi;
      end else if (iControlSignal == OPMFLO) begin
         oResult = r_lo;
      end else begin
         oResult = 32'd0;
      end
   end

   assign oBusy    = r_busy;
   assign oDone    = r_done;
   assign oDivZero = r_divz;
   assign oHI      = r_hi;
   assign oLO      = r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed cases plus randomized traffic
// checked every cycle against a plain-arithmetic model of HI/LO and timing.
module tb_mul_div_unit;
   import mul_div_unit_pkg::*;

   logic        iCLK = 1'b0;
   logic        iRST_n = 1'b0;
   logic        iStart = 1'b0;
   logic [4:0]  iControlSignal = 5'd0;
   logic [31:0] iA = 32'd0;
   logic [31:0] iB = 32'd0;
   logic        oBusy;
   logic        oDone;
   logic        oDivZero;
   logic [31:0] oHI;
   logic [31:0] oLO;
   logic [31:0] oResult;

   int checks = 0;
   int failures = 0;

   // Model state
   int          m_left = 0;
   logic [31:0] m_hi = 32'd0, m_lo = 32'd0, p_hi = 32'd0, p_lo = 32'd0;
   logic        m_done = 1'b0, m_dz = 1'b0, p_dz = 1'b0;

   mul_div_unit dut (
      .iCLK           (iCLK),
      .iRST_n         (iRST_n),
      .iStart         (iStart),
      .iControlSignal (iControlSignal),
      .iA             (iA),
      .iB             (iB),
      .oBusy          (oBusy),
      .oDone          (oDone),
      .oDivZero       (oDivZero),
      .oHI            (oHI),
      .oLO            (oLO),
      .oResult        (oResult)
   );

   always #5 iCLK = ~iCLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Work out what an accepted request does, using plain arithmetic
   task automatic model_accept();
      longint      sa, sb, q, r;
      logic [63:0] pu;
      case (iControlSignal)
         OPMULTU: begin
            pu = {32'd0, iA} * {32'd0, iB};
            {p_hi, p_lo} = pu; p_dz = 1'b0; m_left = 33;
         end
         OPMULT: begin
            sa = longint'($signed(iA)); sb = longint'($signed(iB));
            pu = 64'(sa * sb);
            {p_hi, p_lo} = pu; p_dz = 1'b0; m_left = 33;
         end
         OPDIVU: begin
            if (iB == 32'd0) begin p_lo = 32'hFFFF_FFFF; p_hi = iA; p_dz = 1'b1; end
            else begin p_lo = iA / iB; p_hi = iA % iB; p_dz = 1'b0; end
            m_left = 33;
         end
         OPDIV: begin
            if (iB == 32'd0) begin p_lo = 32'hFFFF_FFFF; p_hi = iA; p_dz = 1'b1; end
            else begin
               sa = longint'($signed(iA)); sb = longint'($signed(iB));
               q = sa / sb; r = sa % sb;
               p_lo = q[31:0]; p_hi = r[31:0]; p_dz = 1'b0;
            end
            m_left = 33;
         end
         OPMTHI: begin m_hi = iA; m_done = 1'b1; end
         OPMTLO: begin m_lo = iA; m_done = 1'b1; end
         default: ;
      endcase
   endtask

   // Reference model: advances on each clock edge, clears on reset
   initial begin
      forever begin
         @(posedge iCLK or negedge iRST_n);
         if (!iRST_n) begin
            m_left = 0; m_hi = 32'd0; m_lo = 32'd0; m_done = 1'b0; m_dz = 1'b0;
         end else begin
            m_done = 1'b0; m_dz = 1'b0;
            if (m_left > 0) begin
               m_left--;
               if (m_left == 0) begin
                  m_hi = p_hi; m_lo = p_lo; m_dz = p_dz; m_done = 1'b1;
               end
            end else if (iStart) begin
               model_accept();
            end
         end
      end
   end

   // Compare process: every falling edge, all outputs against the model
   initial begin
      logic [31:0] exp_res;
      forever begin
         @(negedge iCLK);
         exp_res = (iControlSignal == OPMFHI) ? m_hi :
                   (iControlSignal == OPMFLO) ? m_lo : 32'd0;
         chk("busy", 32'(oBusy), 32'(m_left > 0));
         chk("done", 32'(oDone), 32'(m_done));
         chk("divzero", 32'(oDivZero), 32'(m_dz));
         chk("hi", oHI, m_hi);
         chk("lo", oLO, m_lo);
         chk("result", oResult, exp_res);
      end
   end

   // Issue one request for a single cycle, then scramble the inputs
   task automatic req(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      @(posedge iCLK); #1;
      iStart = 1'b1; iControlSignal = op; iA = a; iB = b;
      @(posedge iCLK); #1;
      iStart = 1'b0; iControlSignal = 5'd0; iA = $urandom; iB = $urandom;
      $display("req op=%0d a=%h b=%h", op, a, b);
   endtask

   // Wait (bounded) for oDone, counting busy cycles seen on the way
   task automatic wait_done(output int busy_cnt, output logic dz);
      logic found;
      busy_cnt = 0; found = 1'b0; dz = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge iCLK);
         if (oBusy) busy_cnt++;
         if (oDone) begin found = 1'b1; dz = oDivZero; break; end
      end
      checks++;
      if (!found) begin
         failures++;
         $display("FAIL done_timeout: got no oDone expected one within 40 cycles");
      end
      $display("done hi=%h lo=%h busy_cycles=%0d divzero=%0b", oHI, oLO, busy_cnt, dz);
   endtask

   function automatic logic [31:0] pick_val();
      case ($urandom % 6)
         0: return 32'd0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'($urandom % 16);
         default: return 32'($urandom);
      endcase
   endfunction

   function automatic logic [4:0] pick_op();
      logic [4:0] ops [10];
      ops = '{OPMULT, OPMULTU, OPDIV, OPDIVU, OPMTHI, OPMTLO, OPMFHI, OPMFLO, 5'd0, 5'd31};
      return ops[$urandom % 10];
   endfunction

   initial begin
      int   bc;
      logic dz;
      int   ndone;

      // Reset state
      #12;
      chk("reset_busy", 32'(oBusy), 32'd0);
      chk("reset_hi", oHI, 32'd0);
      chk("reset_lo", oLO, 32'd0);
      @(posedge iCLK); #1; iRST_n = 1'b1;

      // Test 1: MULTU max x max
      req(OPMULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done(bc, dz);
      chk("t1_hi", oHI, 32'hFFFF_FFFE);
      chk("t1_lo", oLO, 32'h0000_0001);
      chk("t1_busy_cycles", 32'(bc), 32'd33);
      @(negedge iCLK);
      chk("t1_single_done", 32'(oDone), 32'd0);

      // Test 2: MULT -3 x 7
      req(OPMULT, 32'hFFFF_FFFD, 32'h0000_0007);
      wait_done(bc, dz);
      chk("t2_hi", oHI, 32'hFFFF_FFFF);
      chk("t2_lo", oLO, 32'hFFFF_FFEB);

      // Test 3: DIV -7 / 2 and DIVU 7 / 0
      req(OPDIV, 32'hFFFF_FFF9, 32'h0000_0002);
      wait_done(bc, dz);
      chk("t3_lo", oLO, 32'hFFFF_FFFD);
      chk("t3_hi", oHI, 32'hFFFF_FFFF);
      req(OPDIVU, 32'd7, 32'd0);
      wait_done(bc, dz);
      chk("t3z_lo", oLO, 32'hFFFF_FFFF);
      chk("t3z_hi", oHI, 32'd7);
      chk("t3z_flag", 32'(dz), 32'd1);
      chk("t3z_busy_cycles", 32'(bc), 32'd33);

      // Test 4: most-negative / -1
      req(OPDIV, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done(bc, dz);
      chk("t4_lo", oLO, 32'h8000_0000);
      chk("t4_hi", oHI, 32'd0);
      chk("t4_flag", 32'(dz), 32'd0);

      // Test 5: MTHI, then MULTU with an ignored MTHI during busy
      req(OPMTHI, 32'h0000_1234, 32'd0);
      wait_done(bc, dz);
      chk("t5_mthi", oHI, 32'h0000_1234);
      req(OPMULTU, 32'd2, 32'd3);
      iStart = 1'b1; iControlSignal = OPMTHI; iA = 32'h0000_9999;
      @(posedge iCLK); #1;
      iStart = 1'b0; iControlSignal = OPMFHI;
      @(negedge iCLK);
      chk("t5_mfhi_busy", oResult, 32'h0000_1234);
      iControlSignal = 5'd0;
      wait_done(bc, dz);
      chk("t5_hi", oHI, 32'd0);
      chk("t5_lo", oLO, 32'd6);

      // Test 6: reset in the middle of a DIVU
      req(OPDIVU, 32'hDEAD_BEEF, 32'd3);
      repeat (10) @(posedge iCLK);
      #2; iRST_n = 1'b0;
      #1;
      chk("t6_busy", 32'(oBusy), 32'd0);
      chk("t6_hi", oHI, 32'd0);
      chk("t6_lo", oLO, 32'd0);
      @(posedge iCLK); #1; iRST_n = 1'b1;
      ndone = 0;
      repeat (45) begin
         @(negedge iCLK);
         if (oDone) ndone++;
      end
      chk("t6_no_done", 32'(ndone), 32'd0);
      req(OPMULTU, 32'd5, 32'd6);
      wait_done(bc, dz);
      chk("t6_after_lo", oLO, 32'd30);

      // Randomized traffic, including requests while busy and occasional resets
      for (int i = 0; i < 3000; i++) begin
         @(posedge iCLK); #1;
         if ($urandom % 400 == 0) begin
            iRST_n = 1'b0; iStart = 1'b0;
            $display("rand reset at cycle %0d", i);
            @(posedge iCLK); #1;
            iRST_n = 1'b1;
         end else begin
            iStart = ($urandom % 3 == 0);
            iControlSignal = pick_op();
            iA = pick_val();
            iB = pick_val();
            if (iStart && m_left == 0)
               $display("rand req op=%0d a=%h b=%h", iControlSignal, iA, iB);
         end
      end
      @(posedge iCLK); #1; iStart = 1'b0;
      repeat (40) @(posedge iCLK);
      @(negedge iCLK);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
